// File: rtl/dac_reg_spi_slave_pkg.sv
// dac_pkg: shared constants, frame layout and receive-FSM state type for
// the DAC register SPI slave.
//   CH_NUM   number of DAC channels
//   DAC_W    DAC code width
//   FRAME_W  SPI frame length
//   DAC_MID  mid-scale code, the reset value of both channel banks
package dac_pkg;

    localparam int CH_NUM  = 8;
    localparam int DAC_W   = 12;
    localparam int FRAME_W = 16;
    localparam int CH_W    = $clog2(CH_NUM);

    localparam logic [DAC_W-1:0] DAC_MID = 12'd2048;

    typedef struct packed {
        logic        load;
        logic [2:0]  ch;
        logic [11:0] code;
    } dac_frame_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_WRITE = 2'd3
    } dac_rx_state_e;

endpackage

// File: rtl/dac_reg_spi_slave_if.sv
// dac_reg_spi_slave_if: SPI link between the MCU (master) and the DAC
// register stage (slave).
//   spi_sclk  SPI clock, mode 0
//   spi_cs_n  chip select, active low
//   spi_mosi  command data, MSB first
//   spi_miso  readback data
interface dac_reg_spi_slave_if;

    logic spi_sclk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_sclk,
        output spi_cs_n,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_sclk,
        input  spi_cs_n,
        input  spi_mosi,
        output spi_miso
    );

endinterface

// File: rtl/dac_reg_spi_slave_sync_2ff.sv
// sync_2ff: two-flop synchroniser bank for asynchronous inputs.
//   clk_core  destination clock
//   rst_n     asynchronous active-low reset, both stages clear to 0
//   d         asynchronous inputs
//   q         synchronised outputs
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_core,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/dac_reg_spi_slave.sv
// dac_reg_spi_slave: receives 16-bit command frames {LOAD, ch[2:0], code[11:0]}
// over an SPI mode-0 slave link, writes them into a shadow bank, and on LOAD
// copies the whole shadow bank to the output bank in a single cycle.
//   clk_core   core clock, all logic in this domain
//   rst_n      asynchronous active-low reset
//   spi        SPI slave modport (sclk, cs_n, mosi in; miso out)
//   ch_data    output bank, one DAC code per channel
//   dac_en     high once the output bank has been loaded
//   upd_pulse  one-cycle pulse per output-bank load
//   frame_err  one-cycle pulse per discarded frame
// Build option: define DAC_REG_READBACK_EN to shift the shadow value of the
// last written channel out on spi_miso; otherwise spi_miso is tied low.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for a chip-select fall
// ST_SHIFT | shifting MOSI bits on each sclk rise until cs rises
// ST_CHECK | frame length check; bad length pulses frame_err
// ST_WRITE | shadow write, optional load of the output bank
module dac_reg_spi_slave
    import dac_pkg::*;
#(
    parameter logic [DAC_W-1:0] RST_CODE = DAC_MID
) (
    input  logic                 clk_core,
    input  logic                 rst_n,
    dac_reg_spi_slave_if.slave   spi,
    output logic [DAC_W-1:0]     ch_data [0:CH_NUM-1],
    output logic                 dac_en,
    output logic                 upd_pulse,
    output logic                 frame_err
);

    localparam logic [4:0] CNT_MAX = 5'd31;

    // Synchronisers and delay flops clear to 0 so that a cs held low through
    // reset release is never seen as a fall: the rest of an interrupted frame
    // is ignored until cs genuinely goes high and then low again.
    logic [2:0] sync_s;
    logic       sclk_s, cs_n_s, mosi_s;

    sync_2ff #(.WIDTH(3)) u_sync (
        .clk_core (clk_core),
        .rst_n    (rst_n),
        .d        ({spi.spi_sclk, spi.spi_cs_n, spi.spi_mosi}),
        .q        (sync_s)
    );

    assign {sclk_s, cs_n_s, mosi_s} = sync_s;

    logic sclk_dly_q, sclk_dly_d;
    logic cs_n_dly_q, cs_n_dly_d;
    logic sclk_rise, cs_fall, cs_rise;

    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign cs_fall   = ~cs_n_s & cs_n_dly_q;
    assign cs_rise   = cs_n_s & ~cs_n_dly_q;

    dac_rx_state_e          state_q, state_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]     shreg_q, shreg_d;
    logic [DAC_W-1:0]       shadow_q [CH_NUM];
    logic [DAC_W-1:0]       shadow_d [CH_NUM];
    logic [DAC_W-1:0]       ch_data_q [CH_NUM];
    logic [DAC_W-1:0]       ch_data_d [CH_NUM];
    logic                   dac_en_q, dac_en_d;
    logic                   upd_pulse_q, upd_pulse_d;
    logic                   frame_err_q, frame_err_d;
    dac_frame_t             frame;

    assign frame = dac_frame_t'(shreg_q);

    always_comb begin
        sclk_dly_d  = sclk_s;
        cs_n_dly_d  = cs_n_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        shadow_d    = shadow_q;
        ch_data_d   = ch_data_q;
        dac_en_d    = dac_en_q;
        upd_pulse_d = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                // A bit arriving with the cs rise is still taken before CHECK.
                if (sclk_rise) begin
                    shreg_d = {shreg_q[FRAME_W-2:0], mosi_s};
                    if (bit_cnt_q != CNT_MAX) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                if (cs_rise) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bit_cnt_q == 5'(FRAME_W)) begin
                    state_d = ST_WRITE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_WRITE: begin
                shadow_d[frame.ch] = frame.code;
                if (frame.load) begin
                    // Copy from shadow_d so the channel written now goes through.
                    ch_data_d   = shadow_d;
                    upd_pulse_d = 1'b1;
                    dac_en_d    = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            sclk_dly_q  <= 1'b0;
            cs_n_dly_q  <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            dac_en_q    <= 1'b0;
            upd_pulse_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) begin
                shadow_q[i]  <= RST_CODE;
                ch_data_q[i] <= RST_CODE;
            end
        end else begin
            sclk_dly_q  <= sclk_dly_d;
            cs_n_dly_q  <= cs_n_dly_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            dac_en_q    <= dac_en_d;
            upd_pulse_q <= upd_pulse_d;
            frame_err_q <= frame_err_d;
            shadow_q    <= shadow_d;
            ch_data_q   <= ch_data_d;
        end
    end

    assign ch_data   = ch_data_q;
    assign dac_en    = dac_en_q;
    assign upd_pulse = upd_pulse_q;
    assign frame_err = frame_err_q;

`ifdef DAC_REG_READBACK_EN
    // Readback word is captured when a frame starts, so it reflects the
    // shadow contents after the previous frame's write.
    logic                sclk_fall;
    logic [CH_W-1:0]     last_ch_q, last_ch_d;
    logic [FRAME_W-1:0]  miso_sr_q, miso_sr_d;

    assign sclk_fall = ~sclk_s & sclk_dly_q;

    always_comb begin
        last_ch_d = last_ch_q;
        miso_sr_d = miso_sr_q;
        if (state_q == ST_IDLE && cs_fall) begin
            miso_sr_d = {{(FRAME_W-DAC_W){1'b0}}, shadow_q[last_ch_q]};
        end else if (state_q == ST_SHIFT && sclk_fall) begin
            miso_sr_d = {miso_sr_q[FRAME_W-2:0], 1'b0};
        end
        if (state_q == ST_WRITE) begin
            last_ch_d = frame.ch;
        end
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            last_ch_q <= '0;
            miso_sr_q <= '0;
        end else begin
            last_ch_q <= last_ch_d;
            miso_sr_q <= miso_sr_d;
        end
    end

    assign spi.spi_miso = miso_sr_q[FRAME_W-1];
`else
    assign spi.spi_miso = 1'b0;
`endif

endmodule
